aes_cipher_core: RTL and testbench

- Parametrised successor to the existing AES-128-only round engine: iterative AES encrypt/decrypt core for 128/192/256-bit keys.
- Has a valid/ready input handshake and a valid/ready output handshake.
- Requests round keys by index from an external key store, the keyGen output memory.
- SubBytes parallelism is configurable, so area can be traded for latency.

---
 rtl/aes_pkg.sv | 102 ++++++++++
 rtl/aes_cipher_core_if.sv | 20 ++
 rtl/aes_sbox_col.sv | 46 ++++
 rtl/aes_cipher_core.sv | 137 +++++++++++++
 tb/tb_aes_cipher_core.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, FSM states, GF(2^8) arithmetic
// and the byte-permutation / column-mixing helpers used by the round datapath.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned COL_W   = 32;

  localparam logic [1:0] KEYLEN_128 = 2'd0;
  localparam logic [1:0] KEYLEN_192 = 2'd1;
  localparam logic [1:0] KEYLEN_256 = 2'd2;

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;

  // Reserved encoding 3 falls through to the AES-128 round count.
  function automatic logic [3:0] nr(input logic [1:0] keylen);
    case (keylen)
      KEYLEN_192: return 4'd12;
      KEYLEN_256: return 4'd14;
      default:    return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [COL_W-1:0] mix_column(input logic [COL_W-1:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [COL_W-1:0] inv_mix_column(input logic [COL_W-1:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Column c occupies the 32 bits starting at the MSB end (byte 4c is bits [127-32c -: 8]).
  function automatic logic [COL_W-1:0] get_col(input logic [BLOCK_W-1:0] b, input logic [1:0] c);
    return b[127 - 32*c -: 32];
  endfunction

  function automatic logic [BLOCK_W-1:0] set_col(input logic [BLOCK_W-1:0] b, input logic [1:0] c,
                                                 input logic [COL_W-1:0] v);
    logic [BLOCK_W-1:0] o;
    o = b;
    o[127 - 32*c -: 32] = v;
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] b);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = b[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] b);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*((c + r) % 4) + r) -: 8] = b[127 - 8*(4*c + r) -: 8];
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] b);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = mix_column(b[127 - 32*c -: 32]);
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] b);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = inv_mix_column(b[127 - 32*c -: 32]);
    return o;
  endfunction

endpackage

// File: rtl/aes_cipher_core_if.sv
// Block handshake, round-key request and status bundle between the cipher core
// and its surroundings (block source, result sink, key store).
interface aes_cipher_core_if;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [1:0]   keylen;
  logic [127:0] block_in;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] block_out;
  logic         busy;

  modport master (output in_valid, mode, keylen, block_in, round_key, out_ready,
                  input  in_ready, round, out_valid, block_out, busy);
  modport slave  (input  in_valid, mode, keylen, block_in, round_key, out_ready,
                  output in_ready, round, out_valid, block_out, busy);
endinterface

// File: rtl/aes_sbox_col.sv
// Four-byte forward/inverse AES S-box, computed as GF(2^8) inversion plus the
// affine transform rather than a lookup table.
module aes_sbox_col
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] din,
  input  logic             inv,
  output logic [COL_W-1:0] dout
);

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'(b << n) | 8'(b >> (8 - n));
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] b, input logic inverse);
    logic [7:0] y;
    if (inverse) begin
      y = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
      return gf_inv(y);
    end
    y = gf_inv(b);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) dout[8*i +: 8] = sbox_byte(din[8*i +: 8], inv);
  end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 encrypt/decrypt engine; round keys are fetched by
// index from an external key store, S-box width selectable (4 or 16 lanes).
module aes_cipher_core
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_LANES = 16
) (
  input  logic              clk,
  input  logic              rst,
  aes_cipher_core_if.slave  bus
);

  localparam int unsigned COLS     = SBOX_LANES / 4;
  localparam int unsigned SUBS     = 4 / COLS;
  localparam logic [1:0]  SUB_LAST = 2'(SUBS - 1);

  state_t             fsm_q, fsm_d;
  logic               mode_q, mode_d;
  logic [3:0]         nr_q, nr_d;
  logic [3:0]         round_q, round_d;
  logic [1:0]         sub_q, sub_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [COL_W-1:0]   col_in  [COLS];
  logic [COL_W-1:0]   col_out [COLS];
  logic [BLOCK_W-1:0] sub_state, fin_state;
  logic               accept, last_sub, final_round;

  assign bus.in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && bus.out_ready);
  assign bus.round     = round_q;
  assign bus.out_valid = out_valid_q;
  assign bus.block_out = data_q;
  assign bus.busy      = busy_q;

  assign accept      = bus.in_valid && bus.in_ready;
  assign last_sub    = (sub_q == SUB_LAST);
  assign final_round = mode_q ? (round_q == 4'd0) : (round_q == nr_q);

  // With 4 lanes sub_q picks the column; with 16 lanes sub_q stays 0 and lane g is column g.
  for (genvar g = 0; g < COLS; g++) begin : g_sbox
    assign col_in[g] = get_col(data_q, 2'(g) + sub_q);
    aes_sbox_col u_sbox (.din(col_in[g]), .inv(mode_q), .dout(col_out[g]));
  end

  always_comb begin
    sub_state = data_q;
    for (int unsigned g = 0; g < COLS; g++)
      sub_state = set_col(sub_state, 2'(g) + sub_q, col_out[g]);
  end

  // Substitution already done column-wise, so only the permutation/mix/key remain.
  always_comb begin
    if (mode_q) begin
      fin_state = inv_shift_rows(sub_state) ^ bus.round_key;
      if (round_q != 4'd0) fin_state = inv_mix_columns(fin_state);
    end else begin
      fin_state = shift_rows(sub_state);
      if (round_q != nr_q) fin_state = mix_columns(fin_state);
      fin_state = fin_state ^ bus.round_key;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    mode_d  = mode_q;
    nr_d    = nr_q;
    round_d = round_q;
    sub_d   = sub_q;
    data_d  = data_q;

    case (fsm_q)
      IDLE: ;
      INIT: begin
        data_d  = data_q ^ bus.round_key;
        round_d = mode_q ? round_q - 4'd1 : round_q + 4'd1;
        sub_d   = '0;
        fsm_d   = ROUND;
      end
      ROUND: begin
        if (last_sub) begin
          data_d = fin_state;
          sub_d  = '0;
          if (final_round) fsm_d = DONE;
          else round_d = mode_q ? round_q - 4'd1 : round_q + 4'd1;
        end else begin
          data_d = sub_state;
          sub_d  = sub_q + 2'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d   = IDLE;
          round_d = '0;
        end
      end
      default: fsm_d = IDLE;
    endcase

    // Accept only happens in IDLE or in DONE while the result is being taken.
    if (accept) begin
      mode_d  = bus.mode;
      nr_d    = nr(bus.keylen);
      round_d = bus.mode ? nr(bus.keylen) : 4'd0;
      data_d  = bus.block_in;
      sub_d   = '0;
      fsm_d   = INIT;
    end

    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      mode_q      <= 1'b0;
      nr_q        <= 4'd10;
      round_q     <= '0;
      sub_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      mode_q      <= mode_d;
      nr_q        <= nr_d;
      round_q     <= round_d;
      sub_q       <= sub_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed FIPS-197 vector bench for aes_cipher_core in 16-lane and 4-lane builds,
// with a behavioural key store that expands the cipher key into round keys.
module tb_aes_cipher_core;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic         in_valid = 1'b0;
  logic         mode = 1'b0;
  logic [1:0]   keylen = 2'd0;
  logic [127:0] block_in = '0;
  logic         out_ready = 1'b1;

  logic [7:0]   tb_sbox [256];
  logic [127:0] ks [16];
  int           trace [400];
  int           checks = 0;
  int           passed = 0;

  aes_cipher_core_if bus16 ();
  aes_cipher_core_if bus4 ();

  aes_cipher_core #(.SBOX_LANES(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  aes_cipher_core #(.SBOX_LANES(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

  always #5 clk = ~clk;

  assign bus16.in_valid  = in_valid & ~sel;
  assign bus4.in_valid   = in_valid & sel;
  assign bus16.mode      = mode;
  assign bus4.mode       = mode;
  assign bus16.keylen    = keylen;
  assign bus4.keylen     = keylen;
  assign bus16.block_in  = block_in;
  assign bus4.block_in   = block_in;
  assign bus16.out_ready = out_ready;
  assign bus4.out_ready  = out_ready;
  assign bus16.round_key = ks[bus16.round];
  assign bus4.round_key  = ks[bus4.round];

  logic         obs_in_ready, obs_out_valid, obs_busy;
  logic [3:0]   obs_round;
  logic [127:0] obs_block;
  assign obs_in_ready  = sel ? bus4.in_ready  : bus16.in_ready;
  assign obs_out_valid = sel ? bus4.out_valid : bus16.out_valid;
  assign obs_busy      = sel ? bus4.busy      : bus16.busy;
  assign obs_round     = sel ? bus4.round     : bus16.round;
  assign obs_block     = sel ? bus4.block_out : bus16.block_out;

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'(b << n) | 8'(b >> (8 - n));
  endfunction

  // S-box built by walking the multiplicative group with generator 3.
  task automatic init_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      tb_sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    tb_sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  task automatic load_keys(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nrounds;
    nrounds = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nrounds + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) ks[r] = '0;
    for (int r = 0; r <= nrounds; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic int exp_round(input logic m, input int nrv, input int s, input int k);
    if (m) return (k == 0) ? nrv : nrv - 1 - (k - 1) / s;
    return (k == 0) ? 0 : 1 + (k - 1) / s;
  endfunction

  // Leaves the bench #1 after the accept edge.
  task automatic send(input logic m, input logic [1:0] kl, input logic [127:0] b);
    @(negedge clk);
    mode = m; keylen = kl; block_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // k counts edges since accept; lat = -1 if out_valid never rose.
  task automatic capture(input int k0, output int lat);
    lat = -1;
    for (int k = k0; k < 400; k++) begin
      if (obs_out_valid) begin lat = k; break; end
      trace[k] = int'(obs_round);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    checks++; if (bus16.round !== 4'd0) $display("FAIL reset_round: got %0d expected 0", bus16.round); else passed++;
    checks++; if (bus16.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus16.out_valid); else passed++;
    checks++; if (bus16.block_out !== 128'h0) $display("FAIL reset_block_out: got %h expected 0", bus16.block_out); else passed++;
    checks++; if (bus16.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus16.busy); else passed++;
    checks++; if (bus16.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus16.in_ready); else passed++;
    checks++; if (bus4.block_out !== 128'h0 || bus4.busy !== 1'b0)
      $display("FAIL reset_lanes4: got block %h busy %b expected 0/0", bus4.block_out, bus4.busy); else passed++;
  endtask

  task automatic test_aes128_enc;
    int lat, bad;
    sel = 1'b0; out_ready = 1'b1;
    load_keys(K128, 4);
    send(1'b0, 2'd0, PT);
    capture(0, lat);
    checks++; if (lat !== 11) $display("FAIL aes128_latency: got %0d expected 11", lat); else passed++;
    checks++; if (obs_block !== CT128) $display("FAIL aes128_result: got %h expected %h", obs_block, CT128); else passed++;
    bad = 0;
    for (int k = 0; k < 11; k++) if (trace[k] !== exp_round(1'b0, 10, 1, k)) bad++;
    checks++; if (bad !== 0) $display("FAIL aes128_round_trace: got %0d wrong cycles expected 0", bad); else passed++;
    @(posedge clk); #1;
    checks++; if (obs_out_valid !== 1'b0 || obs_busy !== 1'b0)
      $display("FAIL aes128_release: got out_valid %b busy %b expected 0/0", obs_out_valid, obs_busy); else passed++;
  endtask

  task automatic test_aes256_dec;
    int lat, bad;
    sel = 1'b0; out_ready = 1'b1;
    load_keys(K256, 8);
    send(1'b1, 2'd2, CT256);
    capture(0, lat);
    checks++; if (lat !== 15) $display("FAIL aes256_latency: got %0d expected 15", lat); else passed++;
    checks++; if (obs_block !== PT) $display("FAIL aes256_result: got %h expected %h", obs_block, PT); else passed++;
    bad = 0;
    for (int k = 0; k < 15; k++) if (trace[k] !== exp_round(1'b1, 14, 1, k)) bad++;
    checks++; if (bad !== 0) $display("FAIL aes256_round_trace: got %0d wrong cycles expected 0", bad); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_aes192_lanes4;
    int lat, bad;
    sel = 1'b1; out_ready = 1'b1;
    load_keys(K192, 6);
    send(1'b0, 2'd1, PT);
    capture(0, lat);
    checks++; if (lat !== 49) $display("FAIL aes192_latency: got %0d expected 49", lat); else passed++;
    checks++; if (obs_block !== CT192) $display("FAIL aes192_result: got %h expected %h", obs_block, CT192); else passed++;
    bad = 0;
    for (int k = 0; k < 49; k++) if (trace[k] !== exp_round(1'b0, 12, 4, k)) bad++;
    checks++; if (bad !== 0) $display("FAIL aes192_round_trace: got %0d wrong cycles expected 0", bad); else passed++;
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic test_keylen3;
    int lat;
    sel = 1'b0; out_ready = 1'b1;
    load_keys(K128, 4);
    send(1'b0, 2'd3, PT);
    capture(0, lat);
    checks++; if (lat !== 11) $display("FAIL keylen3_latency: got %0d expected 11", lat); else passed++;
    checks++; if (obs_block !== CT128) $display("FAIL keylen3_result: got %h expected %h", obs_block, CT128); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat, bad;
    sel = 1'b0; out_ready = 1'b0;
    load_keys(K128, 4);
    send(1'b0, 2'd0, PT);
    capture(0, lat);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (obs_out_valid !== 1'b1 || obs_block !== CT128 || obs_in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL backpressure_hold: got %0d bad cycles expected 0", bad); else passed++;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; keylen = 2'd0; block_in = CT128;
    #1;
    checks++; if (obs_in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b expected 1", obs_in_ready); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (obs_out_valid !== 1'b0 || obs_busy !== 1'b1)
      $display("FAIL b2b_init: got out_valid %b busy %b expected 0/1", obs_out_valid, obs_busy); else passed++;
    checks++; if (obs_round !== 4'd10) $display("FAIL b2b_init_round: got %0d expected 10", obs_round); else passed++;
    capture(0, lat);
    checks++; if (lat !== 11) $display("FAIL b2b_latency: got %0d expected 11", lat); else passed++;
    checks++; if (obs_block !== PT) $display("FAIL b2b_result: got %h expected %h", obs_block, PT); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_busy;
    int lat, bad;
    sel = 1'b0; out_ready = 1'b1;
    load_keys(K128, 4);
    send(1'b0, 2'd0, PT);
    @(negedge clk);
    in_valid = 1'b1; mode = 1'b1; keylen = 2'd2; block_in = '1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (obs_in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++; if (bad !== 0) $display("FAIL busy_in_ready: got %0d ready cycles expected 0", bad); else passed++;
    checks++; if (obs_round !== 4'd3) $display("FAIL busy_round: got %0d expected 3", obs_round); else passed++;
    capture(3, lat);
    checks++; if (lat !== 11) $display("FAIL busy_latency: got %0d expected 11", lat); else passed++;
    checks++; if (obs_block !== CT128) $display("FAIL busy_result: got %h expected %h", obs_block, CT128); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    sel = 1'b0; out_ready = 1'b1;
    load_keys(K128, 4);
    send(1'b0, 2'd0, PT);
    for (int i = 0; i < 50 && obs_round != 4'd5; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (obs_round !== 4'd5) $display("FAIL midreset_reach_round5: got %0d expected 5", obs_round); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (obs_out_valid !== 1'b0 || obs_busy !== 1'b0)
      $display("FAIL midreset_flags: got out_valid %b busy %b expected 0/0", obs_out_valid, obs_busy); else passed++;
    checks++; if (obs_block !== 128'h0) $display("FAIL midreset_block_out: got %h expected 0", obs_block); else passed++;
    checks++; if (obs_round !== 4'd0) $display("FAIL midreset_round: got %0d expected 0", obs_round); else passed++;
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 2'd0, PT);
    capture(0, lat);
    checks++; if (lat !== 11) $display("FAIL midreset_latency: got %0d expected 11", lat); else passed++;
    checks++; if (obs_block !== CT128) $display("FAIL midreset_result: got %h expected %h", obs_block, CT128); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int r = 0; r < 16; r++) ks[r] = '0;
    init_sbox();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_aes128_enc();
    test_aes256_dec();
    test_aes192_lanes4();
    test_keylen3();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
